// File: rtl/ham_secded_stream_decoder.sv
`default_nettype none
// ============================================================================
// Module  : ham_secded_stream_decoder
// Purpose : Two-stage SECDED (extended Hamming) stream decoder with valid/ready
//           flow control and saturating single/double error counters.
//           Optional fault-injection port inj_mask when HAM_ERR_INJECT_EN is defined.
// Rev     : 1.0  initial release
// ============================================================================
module ham_secded_stream_decoder #(
   parameter int  DATA_W = 8,
   parameter int  CNT_W  = 16,
   // Fixed-point iteration of P = clog2(DATA_W+P+1), starting from a lower bound
   localparam int P      = $clog2(DATA_W + 1 + $clog2(DATA_W + 1 + $clog2(DATA_W + 1 + $clog2(DATA_W + 1)))),
   localparam int CW_W   = DATA_W + P + 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [CW_W-1:0]   in_code,
`ifdef HAM_ERR_INJECT_EN
   input  logic [CW_W-1:0]   inj_mask,
`endif
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [P-1:0]      out_syndrome,
   output logic              out_single,
   output logic              out_double,
   input  logic              cnt_clr,
   output logic [CNT_W-1:0]  err_cnt_single,
   output logic [CNT_W-1:0]  err_cnt_double
);

   logic              s1_valid_q, s1_valid_d;
   logic [CW_W-2:0]   s1_code_q, s1_code_d;
   logic [P-1:0]      s1_syn_q, s1_syn_d;
   logic              s1_par_q, s1_par_d;
   logic              out_valid_q, out_valid_d;
   logic [DATA_W-1:0] out_data_q, out_data_d;
   logic [P-1:0]      out_syn_q, out_syn_d;
   logic              out_single_q, out_single_d;
   logic              out_double_q, out_double_d;
   logic [CNT_W-1:0]  cnt_single_q, cnt_single_d;
   logic [CNT_W-1:0]  cnt_double_q, cnt_double_d;

   logic [CW_W-1:0]   w_code;
   logic [P-1:0]      w_syn;
   logic              w_par;
   logic              w_s2_adv;
   logic              w_fire;
   logic              w_flip;
   logic              w_single;
   logic              w_double;
   logic [CW_W-2:0]   w_fix;
   logic [DATA_W-1:0] w_data;

`ifdef HAM_ERR_INJECT_EN
   assign w_code = in_code ^ inj_mask;
`else
   assign w_code = in_code;
`endif

   // Syndrome is the XOR of the (1-based) positions of all set bits below the overall parity bit
   always_comb begin
      w_syn = '0;
      for (int i = 0; i < CW_W - 1; i++) begin
         if (w_code[i]) w_syn = w_syn ^ P'(i + 1);
      end
      w_par = ^w_code;
   end

   always_comb begin
      w_single = 1'b0;
      w_double = 1'b0;
      w_flip   = 1'b0;
      if (s1_par_q) begin
         if (s1_syn_q == '0) begin
            w_single = 1'b1;
         end else if (s1_syn_q <= P'(CW_W - 1)) begin
            w_single = 1'b1;
            w_flip   = 1'b1;
         end else begin
            w_double = 1'b1;
         end
      end else if (s1_syn_q != '0) begin
         w_double = 1'b1;
      end
   end

   always_comb begin
      int k;
      k     = 0;
      w_fix = s1_code_q;
      for (int i = 0; i < CW_W - 1; i++) begin
         if (w_flip && (s1_syn_q == P'(i + 1))) w_fix[i] = ~w_fix[i];
      end
      w_data = '0;
      for (int pos = 1; pos < CW_W; pos++) begin
         if ((pos & (pos - 1)) != 0) begin
            w_data[k] = w_fix[pos-1];
            k = k + 1;
         end
      end
   end

   assign w_s2_adv = !out_valid_q || out_ready;
   assign w_fire   = out_valid_q && out_ready;
   assign in_ready = !s1_valid_q || w_s2_adv;

   always_comb begin
      s1_valid_d   = s1_valid_q;
      s1_code_d    = s1_code_q;
      s1_syn_d     = s1_syn_q;
      s1_par_d     = s1_par_q;
      out_valid_d  = out_valid_q;
      out_data_d   = out_data_q;
      out_syn_d    = out_syn_q;
      out_single_d = out_single_q;
      out_double_d = out_double_q;
      cnt_single_d = cnt_single_q;
      cnt_double_d = cnt_double_q;

      if (in_ready) begin
         s1_valid_d = in_valid;
         if (in_valid) begin
            s1_code_d = w_code[CW_W-2:0];
            s1_syn_d  = w_syn;
            s1_par_d  = w_par;
         end
      end

      if (w_s2_adv) begin
         out_valid_d = s1_valid_q;
         if (s1_valid_q) begin
            out_data_d   = w_data;
            out_syn_d    = s1_syn_q;
            out_single_d = w_single;
            out_double_d = w_double;
         end
      end

      // Clear wins over a coincident delivery; counters stick at all-ones
      if (cnt_clr) begin
         cnt_single_d = '0;
         cnt_double_d = '0;
      end else if (w_fire) begin
         if (out_single_q && (cnt_single_q != '1)) cnt_single_d = cnt_single_q + 1'b1;
         if (out_double_q && (cnt_double_q != '1)) cnt_double_d = cnt_double_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid_q   <= 1'b0;
         s1_code_q    <= '0;
         s1_syn_q     <= '0;
         s1_par_q     <= 1'b0;
         out_valid_q  <= 1'b0;
         out_data_q   <= '0;
         out_syn_q    <= '0;
         out_single_q <= 1'b0;
         out_double_q <= 1'b0;
         cnt_single_q <= '0;
         cnt_double_q <= '0;
      end else begin
         s1_valid_q   <= s1_valid_d;
         s1_code_q    <= s1_code_d;
         s1_syn_q     <= s1_syn_d;
         s1_par_q     <= s1_par_d;
         out_valid_q  <= out_valid_d;
         out_data_q   <= out_data_d;
         out_syn_q    <= out_syn_d;
         out_single_q <= out_single_d;
         out_double_q <= out_double_d;
         cnt_single_q <= cnt_single_d;
         cnt_double_q <= cnt_double_d;
      end
   end

   assign out_valid      = out_valid_q;
   assign out_data       = out_data_q;
   assign out_syndrome   = out_syn_q;
   assign out_single     = out_single_q;
   assign out_double     = out_double_q;
   assign err_cnt_single = cnt_single_q;
   assign err_cnt_double = cnt_double_q;

endmodule
`default_nettype wire

// File: tb/tb_ham_secded_stream_decoder.sv
`default_nettype none
// ============================================================================
// Module  : tb_ham_secded_stream_decoder
// Purpose : Directed and randomized checks of ham_secded_stream_decoder against
//           a behavioural SECDED model (DATA_W=4/CNT_W=2 and DATA_W=8/CNT_W=16).
// Rev     : 1.0  initial release
// ============================================================================
module tb_ham_secded_stream_decoder;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   // Instance A: DATA_W=4, CNT_W=2 (CW_W=8, P=3)
   logic       a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_cnt_clr;
   logic [7:0] a_in_code;
   logic [3:0] a_out_data;
   logic [2:0] a_out_syn;
   logic       a_single, a_double;
   logic [1:0] a_cnt_s, a_cnt_d;

   // Instance B: DATA_W=8, CNT_W=16 (CW_W=13, P=4)
   logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_cnt_clr;
   logic [12:0] b_in_code;
   logic [7:0]  b_out_data;
   logic [3:0]  b_out_syn;
   logic        b_single, b_double;
   logic [15:0] b_cnt_s, b_cnt_d;

   ham_secded_stream_decoder #(.DATA_W(4), .CNT_W(2)) u_dut_a (
      .clk(clk), .rst(rst),
      .in_valid(a_in_valid), .in_ready(a_in_ready), .in_code(a_in_code),
      .out_valid(a_out_valid), .out_ready(a_out_ready),
      .out_data(a_out_data), .out_syndrome(a_out_syn),
      .out_single(a_single), .out_double(a_double),
      .cnt_clr(a_cnt_clr), .err_cnt_single(a_cnt_s), .err_cnt_double(a_cnt_d)
   );

   ham_secded_stream_decoder #(.DATA_W(8), .CNT_W(16)) u_dut_b (
      .clk(clk), .rst(rst),
      .in_valid(b_in_valid), .in_ready(b_in_ready), .in_code(b_in_code),
      .out_valid(b_out_valid), .out_ready(b_out_ready),
      .out_data(b_out_data), .out_syndrome(b_out_syn),
      .out_single(b_single), .out_double(b_double),
      .cnt_clr(b_cnt_clr), .err_cnt_single(b_cnt_s), .err_cnt_double(b_cnt_d)
   );

   int n_vec  = 0;
   int n_miss = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Result packing shared by model and DUT views: data<<10 | syndrome<<2 | single<<1 | double
   function automatic logic [31:0] pk(int d, int s, int sg, int db);
      return 32'((d << 10) | (s << 2) | (sg << 1) | db);
   endfunction

   function automatic logic [31:0] apack();
      return 32'({a_out_data, 5'b0, a_out_syn, a_single, a_double});
   endfunction

   function automatic logic [31:0] bpack();
      return 32'({b_out_data, 4'b0, b_out_syn, b_single, b_double});
   endfunction

   function automatic int npar(int dw);
      int p = 0;
      while ((1 << p) < dw + p + 1) p++;
      return p;
   endfunction

   function automatic logic [31:0] enc(logic [31:0] d, int dw);
      int p = npar(dw);
      int cw = dw + p + 1;
      int k = 0;
      int s = 0;
      logic [31:0] c = '0;
      for (int pos = 1; pos < cw; pos++)
         if ((pos & (pos - 1)) != 0) begin c[pos-1] = d[k]; k++; end
      for (int pos = 1; pos < cw; pos++)
         if (c[pos-1]) s = s ^ pos;
      for (int j = 0; j < p; j++)
         if (s[j]) c[(1 << j) - 1] = 1'b1;
      c[cw-1] = ^c;
      return c;
   endfunction

   function automatic logic [31:0] dec(logic [31:0] code, int dw);
      int p = npar(dw);
      int cw = dw + p + 1;
      int s = 0;
      int par = 0;
      int k = 0;
      int sg = 0;
      int db = 0;
      logic [31:0] c = code;
      logic [31:0] d = '0;
      for (int i = 0; i < cw; i++) begin
         if (code[i]) begin
            par = par ^ 1;
            if (i < cw - 1) s = s ^ (i + 1);
         end
      end
      if (par == 1) begin
         if (s == 0) sg = 1;
         else if (s <= cw - 1) begin sg = 1; c[s-1] = ~c[s-1]; end
         else db = 1;
      end else if (s != 0) begin
         db = 1;
      end
      for (int pos = 1; pos < cw; pos++)
         if ((pos & (pos - 1)) != 0) begin d[k] = c[pos-1]; k++; end
      return pk(int'(d), s, sg, db);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic a_send(input logic [7:0] code);
      int n = 0;
      a_in_code  = code;
      a_in_valid = 1'b1;
      while (!a_in_ready && n < 20) begin tick(); n++; end
      if (n == 20) check("a_in_ready_wait", 32'(a_in_ready), 32'd1);
      tick();
      a_in_valid = 1'b0;
   endtask

   task automatic a_run(input string tag, input logic [7:0] code, input logic [31:0] exp);
      a_send(code);
      check({tag, "_lat1"}, 32'(a_out_valid), 32'd0);
      tick();
      check({tag, "_valid"}, 32'(a_out_valid), 32'd1);
      check(tag, apack(), exp);
      tick();
   endtask

   task automatic b_run(input string tag, input logic [12:0] code, input logic [31:0] exp);
      int n = 0;
      b_in_code  = code;
      b_in_valid = 1'b1;
      while (!b_in_ready && n < 20) begin tick(); n++; end
      if (n == 20) check("b_in_ready_wait", 32'(b_in_ready), 32'd1);
      tick();
      b_in_valid = 1'b0;
      check({tag, "_lat1"}, 32'(b_out_valid), 32'd0);
      tick();
      check({tag, "_valid"}, 32'(b_out_valid), 32'd1);
      check(tag, bpack(), exp);
      tick();
   endtask

   logic [31:0] exp_q[$];
   int          exp_s, exp_d, sent;
   logic        acc;
   logic [31:0] e;
   logic [31:0] cw_r;

   initial begin
      rst = 1'b1;
      a_in_valid = 0; a_in_code = '0; a_out_ready = 1; a_cnt_clr = 0;
      b_in_valid = 0; b_in_code = '0; b_out_ready = 1; b_cnt_clr = 0;
      #3;
      check("rst_a_in_ready", 32'(a_in_ready), 32'd1);
      check("rst_a_out_valid", 32'(a_out_valid), 32'd0);
      check("rst_a_outputs", apack(), 32'd0);
      check("rst_a_counters", 32'({a_cnt_s, a_cnt_d}), 32'd0);
      check("rst_b_in_ready", 32'(b_in_ready), 32'd1);
      check("rst_b_out_valid", 32'(b_out_valid), 32'd0);
      tick(); tick();
      rst = 1'b0;
      tick();

      // Directed DATA_W=4 vectors
      a_run("a_clean_55", 8'h55, pk(4'hB, 0, 0, 0));
      check("a_cnt_s_0", 32'(a_cnt_s), 32'd0);
      a_run("a_pos7_15", 8'h15, pk(4'hB, 7, 1, 0));
      check("a_cnt_s_1", 32'(a_cnt_s), 32'd1);
      a_run("a_dbl_56", 8'h56, pk(4'hB, 3, 0, 1));
      check("a_cnt_d_1", 32'(a_cnt_d), 32'd1);
      check("a_cnt_s_still1", 32'(a_cnt_s), 32'd1);
      a_run("a_ovp_D5", 8'hD5, pk(4'hB, 0, 1, 0));
      check("a_cnt_s_2", 32'(a_cnt_s), 32'd2);

      // Saturation of a 2-bit counter, then clear racing a delivery
      a_cnt_clr = 1'b1; tick(); a_cnt_clr = 1'b0;
      check("a_clr_s", 32'(a_cnt_s), 32'd0);
      check("a_clr_d", 32'(a_cnt_d), 32'd0);
      for (int i = 0; i < 5; i++) a_run("a_sat_word", 8'h15, pk(4'hB, 7, 1, 0));
      check("a_cnt_s_sat", 32'(a_cnt_s), 32'd3);
      a_out_ready = 1'b0;
      a_send(8'h15);
      tick();
      check("a_stall_valid", 32'(a_out_valid), 32'd1);
      tick();
      check("a_stall_hold", apack(), pk(4'hB, 7, 1, 0));
      a_out_ready = 1'b1;
      a_cnt_clr   = 1'b1;
      tick();
      a_cnt_clr   = 1'b0;
      check("a_clr_vs_event", 32'(a_cnt_s), 32'd0);
      check("a_after_deliver", 32'(a_out_valid), 32'd0);

      // DATA_W=8: syndrome 13 with odd parity is an impossible position
      b_run("b_syn13", 13'h0089, pk(0, 13, 0, 1));
      check("b_syn13_model", dec(32'h0089, 8), pk(0, 13, 0, 1));
      check("b_cnt_d_1", 32'(b_cnt_d), 32'd1);

      // Randomized stream with out_ready pattern 1,0,0,1
      b_cnt_clr = 1'b1; tick(); b_cnt_clr = 1'b0;
      exp_s = 0; exp_d = 0; sent = 0; acc = 1'b1;
      for (int cyc = 0; cyc < 3000 && !(sent >= 40 && exp_q.size() == 0); cyc++) begin
         if (acc) begin
            if (sent < 40 && $urandom_range(0, 3) != 0) begin
               cw_r = enc($urandom & 32'hFF, 8);
               case ($urandom_range(0, 4))
                  1: cw_r[$urandom_range(0, 12)] ^= 1'b1;
                  2: begin
                     int p1 = $urandom_range(0, 12);
                     int p2 = (p1 + $urandom_range(1, 12)) % 13;
                     cw_r[p1] ^= 1'b1; cw_r[p2] ^= 1'b1;
                  end
                  3: begin
                     cw_r[0] ^= 1'b1; cw_r[$urandom_range(1, 6)] ^= 1'b1; cw_r[$urandom_range(7, 12)] ^= 1'b1;
                  end
                  4: cw_r = $urandom & 32'h1FFF;
                  default: ;
               endcase
               b_in_code  = cw_r[12:0];
               b_in_valid = 1'b1;
            end else begin
               b_in_valid = 1'b0;
            end
         end
         b_out_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
         @(negedge clk);
         if (b_out_valid) begin
            if (exp_q.size() == 0) begin
               check("stream_spurious", 32'(b_out_valid), 32'd0);
            end else begin
               check("stream_word", bpack(), exp_q[0]);
               if (b_out_ready) begin
                  e = exp_q.pop_front();
                  if (e[1]) exp_s++;
                  if (e[0]) exp_d++;
               end
            end
         end
         acc = !b_in_valid || b_in_ready;
         if (b_in_valid && b_in_ready) begin
            exp_q.push_back(dec(32'(b_in_code), 8));
            sent++;
         end
         tick();
      end
      b_in_valid = 1'b0;
      check("stream_drain", 32'(exp_q.size()), 32'd0);
      check("stream_cnt_s", 32'(b_cnt_s), 32'(exp_s));
      check("stream_cnt_d", 32'(b_cnt_d), 32'(exp_d));

      // Fill both stages, then reset asynchronously mid-cycle
      b_out_ready = 1'b0;
      b_in_valid  = 1'b1;
      b_in_code   = enc(32'h3C, 8);
      tick();
      b_in_code   = enc(32'hA5, 8);
      tick();
      b_in_valid  = 1'b0;
      check("full_in_ready", 32'(b_in_ready), 32'd0);
      #2;
      rst = 1'b1;
      #1;
      check("mid_rst_out_valid", 32'(b_out_valid), 32'd0);
      check("mid_rst_in_ready", 32'(b_in_ready), 32'd1);
      check("mid_rst_outputs", bpack(), 32'd0);
      check("mid_rst_counters", 32'({b_cnt_s, b_cnt_d}), 32'd0);
      tick();
      rst = 1'b0;
      b_out_ready = 1'b1;
      tick();
      cw_r = enc(32'h5A, 8);
      cw_r[4] ^= 1'b1;
      b_run("post_rst_word", cw_r[12:0], pk(8'h5A, 5, 1, 0));
      check("post_rst_empty", 32'(b_out_valid), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/ham_secded_stream_decoder.md
Name: ham_secded_stream_decoder

Overview:
- Parametrised, pipelined SECDED (extended Hamming) decoder that supersedes the combinational Hamming(7,4) decoder.
- Takes a stream of codewords over a valid/ready handshake and emits corrected data with syndrome and single/double-error flags.
- Keeps saturating error counters.
- Sits between the memory/link read path and downstream consumers.

Parameters:
- DATA_W, 8, data bits per word (>=4).
- P, derived localparam, smallest integer with 2^P >= DATA_W+P+1 (DATA_W=4 -> 3, DATA_W=8 -> 4).
- CW_W, derived localparam, DATA_W+P+1 (codeword width including overall parity bit).
- CNT_W, 16, error counter width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  codeword present.
- in_ready  out  1  decoder accepts codeword this cycle.
- in_code  in  CW_W  codeword.
- out_valid  out  1  result present.
- out_ready  in  1  downstream accepts result.
- out_data  out  DATA_W  corrected data.
- out_syndrome  out  P  Hamming syndrome (error position; 0 = none or overall-parity bit).
- out_single  out  1  single error detected and corrected.
- out_double  out  1  uncorrectable error; data not corrected.
- cnt_clr  in  1  synchronous clear of both counters.
- err_cnt_single  out  CNT_W  count of single-error words delivered.
- err_cnt_double  out  CNT_W  count of double-error words delivered.

Behaviour:
- Codeword layout:
  - in_code[i], i < CW_W-1, is Hamming position i+1.
  - Parity bits sit at power-of-two positions.
  - Data bits fill the remaining positions in ascending order, d0 at the lowest.
  - in_code[CW_W-1] is overall even parity over all CW_W bits.
- Stage 1 (S1): accepts on in_valid && in_ready. Registers the codeword, syndrome S (XOR of position indices of set bits, positions 1..CW_W-1) and overall parity check p (XOR of all CW_W bits).
- Stage 2 (S2): classifies, corrects and extracts data, then registers the outputs.
- Classification:
  - S=0, p=0: clean; flags 0.
  - p=1, S=0: overall parity bit in error; single=1, data unchanged.
  - p=1, 1<=S<=CW_W-1: flip position S; single=1.
  - p=1, S>CW_W-1: impossible position; double=1, no correction.
  - p=0, S!=0: double=1, data extracted uncorrected.
  - single and double are never both 1.
- Latency: 2 cycles from accept to out_valid when out_ready stays high. Throughput is 1 word/cycle.
- Flow control:
  - Each stage holds its contents while its downstream is not ready.
  - S2 advances when !out_valid || out_ready.
  - in_ready = !S1_valid || S2_advance (combinational from out_ready).
  - Outputs stay stable while out_valid && !out_ready.
- Counters:
  - Increment on out_valid && out_ready with the matching flag set.
  - Saturate at all-ones.
  - cnt_clr has priority: counter becomes 0 and a coincident event is not counted.
- Reset (async, any time):
  - Stage valids cleared; out_valid=0.
  - out_data, out_syndrome, out_single, out_double = 0; counters = 0.
  - In-flight words are discarded.
  - in_ready=1 while both stages are empty, including during reset.

Optional Feature:
- Macro: HAM_ERR_INJECT_EN.
- Defined:
  - Adds input port inj_mask [CW_W-1:0].
  - inj_mask is XORed onto in_code at S1 capture, for fault-injection testing.
- Undefined:
  - Port is absent and there is no XOR logic.
  - Behaviour is identical to defined with inj_mask=0.

Test Plan:
- DATA_W=4 (CW_W=8), in_code=8'h55, out_ready=1 -> after 2 cycles out_data=4'hB, out_syndrome=0, single=0, double=0.
- DATA_W=4, in_code=8'h15 (position 7 flipped) -> out_data=4'hB, out_syndrome=7, single=1, err_cnt_single=1.
- DATA_W=4, in_code=8'h56 (positions 1,2 flipped) -> out_syndrome=3, double=1, single=0, out_data=4'hB (uncorrected extraction), err_cnt_double=1. Then in_code=8'hD5 -> syndrome 0, single=1, data 4'hB.
- DATA_W=8 (CW_W=13): inject a syndrome-13 pattern with p=1 -> double=1, data uncorrected. Back-to-back stream of 16 words with out_ready toggling 1,0,0,1 -> no loss or duplication, output order preserved, outputs stable while stalled.
- CNT_W=2: deliver 5 single-error words -> err_cnt_single saturates at 3. Assert cnt_clr in the same cycle as a 6th single-error delivery -> counter reads 0.
- Assert rst mid-stream with both stages full -> out_valid falls immediately, counters 0, in_ready=1. The first word after release decodes correctly with 2-cycle latency.
